// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues word fetches, buffers responses in a 2-entry FIFO, handles redirects.
// Optional performance counters are enabled with the IF_FETCH_PERF_CNT_EN macro.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [1:0]  count_q;
    logic        rd_ptr_q, wr_ptr_q;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        vld_p1;
    logic [31:0] addr_p1;
    logic        pop, push, full;
    logic [2:0]  occ_next;

    assign full      = ({1'b0, count_q} == DEPTH);
    assign id_valid  = (count_q != 2'd0);
    assign id_instr  = id_valid ? fifo_instr[rd_ptr_q] : 32'h0;
    assign id_pc     = id_valid ? fifo_pc[rd_ptr_q]    : 32'h0;
    assign pop       = id_valid & id_ready;
    assign imem_addr = pc_q;

    // Occupancy the buffer will have once the outstanding response lands.
    assign occ_next = {1'b0, count_q} + {2'b0, vld_p1} - {2'b0, pop};

    // A redirect kills the response arriving this cycle (the only one that can be in flight).
    assign push = imem_rvalid & vld_p1 & ~redirect_valid & (~full | pop);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                imem_req = (occ_next < DEPTH) && !redirect_valid;
                if (!redirect_valid && full && !pop)
                    state_d = HOLD;
            end
            HOLD: begin
                if (pop || redirect_valid)
                    state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // Stage p0 -> p1: request issue, PC sequencing and buffer control
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= imem_req;
            if (redirect_valid) begin
                pc_q     <= redirect_pc & 32'hFFFF_FFFC;
                count_q  <= 2'd0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (imem_req)
                    pc_q <= pc_q + 32'd4;
                if (push)
                    wr_ptr_q <= ~wr_ptr_q;
                if (pop)
                    rd_ptr_q <= ~rd_ptr_q;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Stage p1 -> buffer: response capture
    always_ff @(posedge clk) begin
        if (imem_req)
            addr_p1 <= pc_q;
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q]    <= addr_p1;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched   <= 32'd0;
            perf_redirects <= 32'd0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid)
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized self-checking bench for if_fetch_stage against a queue-based fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(TB_RESET_PC), .BUF_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
`ifdef IF_FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_redirects(perf_redirects),
`endif
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_pc(id_pc),
        .id_ready(id_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: decode-visible buffer as queues, plus fetch bookkeeping.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    bit          m_boot, m_hold, m_inf, m_just_reset;
    logic [31:0] m_pc, m_inf_addr;
    int unsigned m_fetched, m_redirects;
    bit          last_req;
    logic [31:0] last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit rdy, input bit redir,
                         input logic [31:0] tgt, input bit spur);
        bit exp_valid, pop, exp_req;
        int occ;
        rst            = r;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rvalid    = last_req | spur;
        imem_rdata     = last_req ? (last_addr ^ 32'hA5A5_0000) : $urandom;
        @(negedge clk);
        exp_valid = (q_pc.size() != 0);
        pop       = exp_valid && rdy;
        occ       = q_pc.size() + int'(m_inf) - int'(pop);
        exp_req   = !m_boot && !m_hold && !redir && (occ < 2);
        if (!r) begin
            check("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req)
                check("imem_addr", imem_addr, m_pc);
            check("id_valid", 32'(id_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("id_pc", id_pc, q_pc[0]);
                check("id_instr", id_instr, q_instr[0]);
            end
            if (m_just_reset) begin
                check("rst_imem_addr", imem_addr, TB_RESET_PC);
                check("rst_id_instr", id_instr, 32'h0);
                check("rst_id_pc", id_pc, 32'h0);
            end
`ifdef IF_FETCH_PERF_CNT_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_redirects", perf_redirects, m_redirects);
`endif
        end
        last_req  = imem_req;
        last_addr = imem_addr;

        if (r) begin
            m_boot = 1; m_hold = 0; m_inf = 0; m_just_reset = 1;
            m_pc = TB_RESET_PC;
            q_pc.delete(); q_instr.delete();
            m_fetched = 0; m_redirects = 0;
        end else begin
            m_just_reset = 0;
            if (m_boot)
                m_boot = 0;
            else if (m_hold) begin
                if (pop || redir) m_hold = 0;
            end else if (!redir && q_pc.size() == 2 && !pop)
                m_hold = 1;
            if (pop) m_fetched++;
            if (redir) begin
                m_redirects++;
                q_pc.delete(); q_instr.delete();
                m_pc  = tgt & 32'hFFFF_FFFC;
                m_inf = 0;
            end else begin
                if (pop) begin
                    void'(q_pc.pop_front());
                    void'(q_instr.pop_front());
                end
                if (imem_rvalid && m_inf) begin
                    q_pc.push_back(m_inf_addr);
                    q_instr.push_back(imem_rdata);
                end
                m_inf = exp_req;
                if (exp_req) begin
                    m_inf_addr = m_pc;
                    m_pc       = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        bit r, rdy, redir, spur;
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        repeat (2) cycle(1, 0, 0, 32'h0, 0);
        // streaming across the 2^32 address wrap
        repeat (10) cycle(0, 1, 0, 32'h0, 0);
        // decode stall: buffer fills, fetch holds, then resumes
        repeat (7) cycle(0, 0, 0, 32'h0, 0);
        repeat (6) cycle(0, 1, 0, 32'h0, 0);
        // redirect with a response in flight; target is misaligned
        cycle(0, 1, 1, 32'h0000_0103, 0);
        repeat (6) cycle(0, 1, 0, 32'h0, 0);
        // unsolicited responses while holding
        repeat (5) cycle(0, 0, 0, 32'h0, 1);
        // reset with buffer full, then reset mid-stream
        cycle(1, 0, 0, 32'h0, 0);
        repeat (8) cycle(0, 1, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h0, 0);
        repeat (6) cycle(0, 1, 0, 32'h0, 0);
        // redirect coinciding with a transfer, and redirect while holding
        cycle(0, 1, 1, 32'hFFFF_FFFE, 0);
        repeat (5) cycle(0, 0, 0, 32'h0, 0);
        cycle(0, 0, 1, 32'h0000_0040, 0);
        repeat (5) cycle(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 400; i++) begin
            r     = ($urandom_range(0, 99) < 2);
            rdy   = ($urandom_range(0, 99) < 70);
            redir = ($urandom_range(0, 99) < 6);
            spur  = ($urandom_range(0, 99) < 20);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            cycle(r, rdy, redir, tgt, spur);
        end
        repeat (6) cycle(0, 1, 0, 32'h0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
